// File: rtl/uart_baud_autodetect_if.sv
// Signal bundle between the auto-baud controller and its surroundings.
//   rx, start, cfg_override, cfg_baud : into the controller (line + control)
//   baud_rate, gen_rst_n              : out to the RX baud-rate generator
//   busy, locked, error               : status back to software
// master = the side driving the line and control (pad sync / CPU),
// slave  = the auto-baud controller itself.
interface uart_baud_autodetect_if;
  logic       rx;
  logic       start;
  logic       cfg_override;
  logic [1:0] cfg_baud;
  logic [1:0] baud_rate;
  logic       gen_rst_n;
  logic       busy;
  logic       locked;
  logic       error;

  modport master (
    output rx, start, cfg_override, cfg_baud,
    input  baud_rate, gen_rst_n, busy, locked, error
  );

  modport slave (
    input  rx, start, cfg_override, cfg_baud,
    output baud_rate, gen_rst_n, busy, locked, error
  );
endinterface

// File: rtl/uart_baud_autodetect.sv
// Auto-baud controller for the UART receive path.
// Measures low-pulse widths on the synchronized rx line, classifies each into
// one of four rate codes, and after NSAMP consistent measurements programs the
// baud generator (baud_rate) and releases its phase reset (gen_rst_n).
// Software may bypass detection with cfg_override/cfg_baud.
// Ports:
//   system_clk : clock
//   reset_n    : asynchronous active-low reset
//   bus        : slave side of uart_baud_autodetect_if (rx, start, cfg_*,
//                baud_rate, gen_rst_n, busy, locked, error)
module uart_baud_autodetect #(
  parameter int unsigned P0    = 41668,
  parameter int unsigned P1    = 20834,
  parameter int unsigned P2    = 10418,
  parameter int unsigned P3    = 6946,
  parameter int unsigned NSAMP = 2
) (
  input  logic                  system_clk,
  input  logic                  reset_n,
  uart_baud_autodetect_if.slave bus
);
  localparam int unsigned MIN_W = P3 / 2;
  localparam int unsigned MAX_W = P0 + P0 / 2;
  localparam int unsigned M01   = (P0 + P1) / 2;
  localparam int unsigned M12   = (P1 + P2) / 2;
  localparam int unsigned M23   = (P2 + P3) / 2;

  localparam logic [16:0] MIN_W_V    = 17'(MIN_W);
  localparam logic [16:0] MAX_W_V    = 17'(MAX_W);
  localparam logic [16:0] SAT_W_V    = 17'(MAX_W + 1);
  localparam logic [16:0] M01_V      = 17'(M01);
  localparam logic [16:0] M12_V      = 17'(M12);
  localparam logic [16:0] M23_V      = 17'(M23);
  localparam logic [16:0] ARM_LAST_V = 17'(P3 - 1);
  localparam logic [2:0]  NSAMP_V    = 3'(NSAMP);

  typedef enum logic [2:0] {
    IDLE, ARM, WAIT_FALL, MEASURE, DONE, FAIL, LOAD
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [16:0] idle_cnt_q, idle_cnt_d;
  logic [16:0] w_q, w_d;
  logic [2:0]  samp_cnt_q, samp_cnt_d;
  logic [1:0]  code_q, code_d;
  logic [1:0]  baud_rate_q, baud_rate_d;
  logic        gen_rst_n_q, gen_rst_n_d;
  logic        busy_q, busy_d;
  logic        locked_q, locked_d;
  logic        error_q, error_d;

  // Rate code of the pulse just measured: longer pulse -> slower rate.
  logic [1:0] cls_code;
  always_comb begin
    if (w_q >= M01_V)      cls_code = 2'b00;
    else if (w_q >= M12_V) cls_code = 2'b01;
    else if (w_q >= M23_V) cls_code = 2'b10;
    else                   cls_code = 2'b11;
  end

  // Decision terms for MEASURE. is_break fires on the cycle that would push
  // W past MAX_W, so W itself never needs to exceed MAX_W+1.
  logic is_break, is_glitch, is_mismatch, is_last;
  assign is_break    = !rx_s_q && (w_q >= MAX_W_V);
  assign is_glitch   = rx_s_q && (w_q < MIN_W_V);
  assign is_mismatch = (samp_cnt_q != 3'd0) && (cls_code != code_q);
  assign is_last     = (samp_cnt_q + 3'd1) == NSAMP_V;

  // rx synchronizer; resets to the idle (high) line level.
  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State register.
  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (bus.start) state_d = bus.cfg_override ? LOAD : ARM;
      ARM:       if (rx_s_q && (idle_cnt_q == ARM_LAST_V)) state_d = WAIT_FALL;
      WAIT_FALL: if (!rx_s_q) state_d = MEASURE;
      MEASURE: begin
        if (is_break)         state_d = FAIL;
        else if (!rx_s_q)     state_d = MEASURE;
        else if (is_glitch)   state_d = WAIT_FALL;
        else if (is_mismatch) state_d = FAIL;
        else if (is_last)     state_d = DONE;
        else                  state_d = WAIT_FALL;
      end
      DONE, FAIL, LOAD: state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // Datapath and output register next values. Results (baud_rate, locked,
  // error) are registered on the transition into DONE/FAIL/LOAD so that the
  // generator sees the new rate one full cycle before gen_rst_n releases.
  always_comb begin
    idle_cnt_d  = idle_cnt_q;
    w_d         = w_q;
    samp_cnt_d  = samp_cnt_q;
    code_d      = code_q;
    baud_rate_d = baud_rate_q;
    gen_rst_n_d = gen_rst_n_q;
    busy_d      = busy_q;
    locked_d    = locked_q;
    error_d     = error_q;
    unique case (state_q)
      IDLE: begin
        gen_rst_n_d = 1'b1;
        if (bus.start) begin
          gen_rst_n_d = 1'b0;
          busy_d      = 1'b1;
          error_d     = 1'b0;
          if (bus.cfg_override) begin
            baud_rate_d = bus.cfg_baud;
            locked_d    = 1'b1;
          end else begin
            locked_d   = 1'b0;
            samp_cnt_d = 3'd0;
            idle_cnt_d = 17'd0;
          end
        end
      end
      ARM:       idle_cnt_d = rx_s_q ? idle_cnt_q + 17'd1 : 17'd0;
      WAIT_FALL: if (!rx_s_q) w_d = 17'd1;
      MEASURE: begin
        if (is_break) begin
          w_d     = SAT_W_V;
          error_d = 1'b1;
        end else if (!rx_s_q) begin
          w_d = w_q + 17'd1;
        end else if (!is_glitch) begin
          if (is_mismatch) begin
            error_d = 1'b1;
          end else begin
            code_d     = cls_code;
            samp_cnt_d = samp_cnt_q + 3'd1;
            if (is_last) begin
              baud_rate_d = cls_code;
              locked_d    = 1'b1;
            end
          end
        end
      end
      DONE, FAIL, LOAD: begin
        gen_rst_n_d = 1'b1;
        busy_d      = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_q  <= '0;
      w_q         <= '0;
      samp_cnt_q  <= '0;
      code_q      <= '0;
      baud_rate_q <= 2'b00;
      gen_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      idle_cnt_q  <= idle_cnt_d;
      w_q         <= w_d;
      samp_cnt_q  <= samp_cnt_d;
      code_q      <= code_d;
      baud_rate_q <= baud_rate_d;
      gen_rst_n_q <= gen_rst_n_d;
      busy_q      <= busy_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
    end
  end

  assign bus.baud_rate = baud_rate_q;
  assign bus.gen_rst_n = gen_rst_n_q;
  assign bus.busy      = busy_q;
  assign bus.locked    = locked_q;
  assign bus.error     = error_q;
endmodule

// File: tb/tb_uart_baud_autodetect.sv
// Bench for uart_baud_autodetect with bit periods scaled down so every
// scenario fits in a short run. Expected results come from a pulse-level
// reference: each valid low pulse maps to the nearest nominal bit period.
module tb_uart_baud_autodetect;
  localparam int TP0 = 400;
  localparam int TP1 = 200;
  localparam int TP2 = 100;
  localparam int TP3 = 66;
  localparam int TNS = 2;
  localparam int MIN_W = TP3 / 2;
  localparam int MAX_W = TP0 + TP0 / 2;

  logic system_clk = 1'b0;
  logic reset_n    = 1'b0;
  int   checks     = 0;
  int   errors     = 0;

  uart_baud_autodetect_if bus ();

  uart_baud_autodetect #(
    .P0(TP0), .P1(TP1), .P2(TP2), .P3(TP3), .NSAMP(TNS)
  ) dut (
    .system_clk(system_clk),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  always #5 system_clk = ~system_clk;

  // Reference model state.
  logic [1:0] m_baud;
  logic       m_locked, m_error, m_done;
  logic [1:0] m_first;
  int         m_cnt;

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge system_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int period_of(input int k);
    case (k)
      0:       return TP0;
      1:       return TP1;
      2:       return TP2;
      default: return TP3;
    endcase
  endfunction

  // Nearest nominal period; ties go to the slower rate.
  function automatic logic [1:0] nearest_code(input int w);
    int best = 0;
    int bd   = 1 << 30;
    int d;
    for (int k = 0; k < 4; k++) begin
      d = (w > period_of(k)) ? w - period_of(k) : period_of(k) - w;
      if (d < bd) begin
        bd   = d;
        best = k;
      end
    end
    return 2'(best);
  endfunction

  function automatic void model_step(input int w);
    logic [1:0] c;
    if (m_done) return;
    if (w > MAX_W) begin
      m_error = 1'b1;
      m_done  = 1'b1;
    end else if (w >= MIN_W) begin
      c = nearest_code(w);
      if (m_cnt > 0 && c != m_first) begin
        m_error = 1'b1;
        m_done  = 1'b1;
      end else begin
        if (m_cnt == 0) m_first = c;
        m_cnt++;
        if (m_cnt == TNS) begin
          m_baud   = c;
          m_locked = 1'b1;
          m_done   = 1'b1;
        end
      end
    end
  endfunction

  task automatic pulse(input int w, input int gap);
    model_step(w);
    bus.rx = 1'b0;
    ticks(w);
    bus.rx = 1'b1;
    ticks(gap);
  endtask

  task automatic start_detect(input string tag);
    bus.cfg_override = 1'b0;
    bus.start        = 1'b1;
    ticks(1);
    bus.start = 1'b0;
    m_cnt = 0; m_done = 1'b0; m_locked = 1'b0; m_error = 1'b0;
    chk({tag, ":busy_on"}, bus.busy, 2'b1);
    chk({tag, ":genrst_low"}, bus.gen_rst_n, 2'b0);
    ticks(TP3 + 5);
  endtask

  task automatic check_outcome(input string tag);
    chk({tag, ":baud"}, bus.baud_rate, m_baud);
    chk({tag, ":locked"}, bus.locked, m_locked);
    chk({tag, ":error"}, bus.error, m_error);
    chk({tag, ":busy"}, bus.busy, 2'b0);
    chk({tag, ":genrst"}, bus.gen_rst_n, 2'b1);
  endtask

  initial begin
    int sel, w, k, glitches;
    int bnd[9];
    bnd = '{MIN_W - 1, MIN_W, 83, 84, 150, 151, 300, 301, MAX_W};

    bus.rx = 1'b1; bus.start = 1'b0; bus.cfg_override = 1'b0; bus.cfg_baud = 2'b00;
    m_baud = 2'b00; m_locked = 1'b0; m_error = 1'b0; m_done = 1'b1; m_first = 2'b00; m_cnt = 0;

    // Reset state.
    #1;
    chk("rst:baud", bus.baud_rate, 2'b00);
    chk("rst:genrst", bus.gen_rst_n, 2'b0);
    chk("rst:busy", bus.busy, 2'b0);
    chk("rst:locked", bus.locked, 2'b0);
    chk("rst:error", bus.error, 2'b0);
    ticks(3);
    reset_n = 1'b1;
    ticks(1);
    chk("rst:genrst_release", bus.gen_rst_n, 2'b1);

    // 0x55 at 38400: start bit, d0 high, d1 low, then check lock timing.
    start_detect("s38400");
    pulse(TP2, TP2);
    model_step(TP2);
    bus.rx = 1'b0;
    ticks(TP2);
    bus.rx = 1'b1;
    ticks(2);
    chk("s38400:pre_locked", bus.locked, 2'b0);
    chk("s38400:pre_baud", bus.baud_rate, 2'b00);
    ticks(1);
    chk("s38400:baud", bus.baud_rate, 2'b10);
    chk("s38400:locked", bus.locked, 2'b1);
    chk("s38400:genrst_held", bus.gen_rst_n, 2'b0);
    ticks(1);
    chk("s38400:genrst_rise", bus.gen_rst_n, 2'b1);
    ticks(TP2 * 6);
    check_outcome("s38400");

    // Break: error exactly when W would pass MAX_W, baud holds 2'b10.
    start_detect("break");
    model_step(700);
    bus.rx = 1'b0;
    ticks(MAX_W + 2);
    chk("break:err_early", bus.error, 2'b0);
    ticks(1);
    chk("break:err_set", bus.error, 2'b1);
    chk("break:genrst_held", bus.gen_rst_n, 2'b0);
    ticks(1);
    chk("break:busy_clr", bus.busy, 2'b0);
    chk("break:genrst_rise", bus.gen_rst_n, 2'b1);
    ticks(700 - (MAX_W + 4));
    bus.rx = 1'b1;
    ticks(10);
    check_outcome("break");

    // Mismatch: 19200-width pulse followed by 57600-width pulse.
    start_detect("mismatch");
    pulse(TP1, 50);
    pulse(TP3, 50);
    ticks(6);
    check_outcome("mismatch");

    // Glitch then 0x55 at 9600.
    start_detect("glitch");
    pulse(10, 50);
    chk("glitch:error_after_glitch", bus.error, 2'b0);
    pulse(TP0, TP0);
    pulse(TP0, TP0);
    ticks(6);
    check_outcome("glitch9600");

    // Override with a second start while busy.
    bus.cfg_override = 1'b1; bus.cfg_baud = 2'b11; bus.start = 1'b1;
    ticks(1);
    m_baud = 2'b11; m_locked = 1'b1; m_error = 1'b0;
    chk("ovr:baud", bus.baud_rate, 2'b11);
    chk("ovr:genrst_low", bus.gen_rst_n, 2'b0);
    chk("ovr:locked", bus.locked, 2'b1);
    chk("ovr:busy", bus.busy, 2'b1);
    bus.cfg_baud = 2'b01;
    ticks(1);
    bus.start = 1'b0; bus.cfg_override = 1'b0;
    chk("ovr:second_start_ignored", bus.baud_rate, 2'b11);
    check_outcome("ovr");

    // Reset in the middle of MEASURE, then a fresh lock.
    start_detect("midrst");
    bus.rx = 1'b0;
    ticks(150);
    reset_n = 1'b0;
    #1;
    m_baud = 2'b00; m_locked = 1'b0; m_error = 1'b0;
    chk("midrst:baud", bus.baud_rate, 2'b00);
    chk("midrst:genrst", bus.gen_rst_n, 2'b0);
    chk("midrst:busy", bus.busy, 2'b0);
    chk("midrst:locked", bus.locked, 2'b0);
    bus.rx = 1'b1;
    ticks(2);
    reset_n = 1'b1;
    ticks(1);
    chk("midrst:genrst_release", bus.gen_rst_n, 2'b1);
    start_detect("relock");
    pulse(TP2, TP2);
    pulse(TP2, TP2);
    ticks(6);
    check_outcome("relock");

    // Randomized runs against the reference model.
    for (int r = 0; r < 10; r++) begin
      start_detect("rand");
      glitches = 0;
      while (!m_done) begin
        sel = int'($urandom_range(0, 99));
        if (sel < 12 && glitches < 3) begin
          w = int'($urandom_range(1, MIN_W - 1));
          glitches++;
        end else if (sel < 24) begin
          w = bnd[$urandom_range(0, 8)];
        end else if (sel < 30) begin
          w = int'($urandom_range(MAX_W + 1, MAX_W + 40));
        end else begin
          k = int'($urandom_range(0, 3));
          w = period_of(k) - period_of(k) / 10 + int'($urandom_range(0, 2 * (period_of(k) / 10)));
        end
        pulse(w, int'($urandom_range(10, 60)));
      end
      ticks(6);
      check_outcome($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
